// File: rtl/game_pkg.sv
// Shared types and defaults for the penalty-shootout game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } game_state_t;

    localparam int ROUNDS_DEF     = 5;
    localparam int END_FRAMES_DEF = 600;

    function automatic logic is_end(input game_state_t s);
        return (s == WINNER) || (s == LOOSER);
    endfunction

endpackage

// File: rtl/end_screen_timer.sv
// Frame down-counter for the end screens; expired fires on the END_FRAMES-th frame_tick after clr drops.
module end_screen_timer #(
    parameter int END_FRAMES = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = $clog2(END_FRAMES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(END_FRAMES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (frame_tick && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign expired = frame_tick && !clr && (cnt == '0);

endmodule

// File: rtl/game_state_ctl.sv
// Game flow controller: START -> SHOOTER/KEEPER rounds -> WINNER/LOOSER -> START.
// All state and score updates commit on frame_tick only.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   START   | title screen, waiting for a click
//   SHOOTER | player shoots; a goal bumps score_player
//   KEEPER  | player keeps; a goal bumps score_cpu, round ends
//   WINNER  | player won; held until click or end timer
//   LOOSER  | player lost; held until click or end timer
module game_state_ctl
    import game_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEF,
    parameter int END_FRAMES = END_FRAMES_DEF,
    parameter int SCORE_W    = 4,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_click,
    input  logic               shot_valid,
    input  logic               shot_goal,
    output game_state_t        game_state,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_cpu,
    output logic [ROUND_W-1:0] round_idx,
    output logic               state_chg
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;
    localparam logic [ROUND_W-1:0] ROUND_ONE = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] ROUNDS_L  = ROUND_W'(ROUNDS);

    logic click_pend, shot_pend, shot_goal_q;
    logic click_ok, shot_ok;
    logic click_ev, shot_ev, goal_ev;
    logic end_clr, end_expired;

    game_state_t        state_n;
    logic [SCORE_W-1:0] sp_n, sc_n;
    logic [ROUND_W-1:0] rd_n;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_ONE;
    endfunction

    assign click_ok = (game_state == START) || is_end(game_state);
    assign shot_ok  = (game_state == SHOOTER) || (game_state == KEEPER);

    // A pulse landing on the same cycle as frame_tick is folded in directly.
    assign click_ev = click_pend || (start_click && click_ok);
    assign shot_ev  = shot_pend || (shot_valid && shot_ok);
    assign goal_ev  = shot_pend ? shot_goal_q : shot_goal;

    assign end_clr = !is_end(game_state);

    end_screen_timer #(
        .END_FRAMES(END_FRAMES)
    ) u_end_timer (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .clr       (end_clr),
        .expired   (end_expired)
    );

    always_comb begin
        state_n = game_state;
        sp_n    = score_player;
        sc_n    = score_cpu;
        rd_n    = round_idx;
        case (game_state)
            START: begin
                if (click_ev) begin
                    state_n = SHOOTER;
                    sp_n    = '0;
                    sc_n    = '0;
                    rd_n    = ROUND_ONE;
                end
            end
            SHOOTER: begin
                if (shot_ev) begin
                    state_n = KEEPER;
                    if (goal_ev) sp_n = sat_inc(score_player);
                end
            end
            KEEPER: begin
                if (shot_ev) begin
                    if (goal_ev) sc_n = sat_inc(score_cpu);
                    if ((round_idx >= ROUNDS_L) && (score_player != sc_n)) begin
                        state_n = (score_player > sc_n) ? WINNER : LOOSER;
                    end else if (round_idx == ROUND_MAX) begin
                        // Out of round numbers while still tied: the player loses rather than wrap.
                        state_n = LOOSER;
                    end else begin
                        state_n = SHOOTER;
                        rd_n    = round_idx + ROUND_ONE;
                    end
                end
            end
            WINNER, LOOSER: begin
                if (click_ev || end_expired) begin
                    state_n = START;
                    rd_n    = '0;
                end
            end
            default: begin
                state_n = START;
                sp_n    = '0;
                sc_n    = '0;
                rd_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_state   <= START;
            score_player <= '0;
            score_cpu    <= '0;
            round_idx    <= '0;
            state_chg    <= 1'b0;
            click_pend   <= 1'b0;
            shot_pend    <= 1'b0;
            shot_goal_q  <= 1'b0;
        end else if (frame_tick) begin
            game_state   <= state_n;
            score_player <= sp_n;
            score_cpu    <= sc_n;
            round_idx    <= rd_n;
            state_chg    <= (state_n != game_state);
            click_pend   <= 1'b0;
            shot_pend    <= 1'b0;
            shot_goal_q  <= 1'b0;
        end else begin
            state_chg <= 1'b0;
            if (start_click && click_ok) click_pend <= 1'b1;
            // First shot of the frame wins; later ones are dropped with their goal flag.
            if (shot_valid && shot_ok && !shot_pend) begin
                shot_pend   <= 1'b1;
                shot_goal_q <= shot_goal;
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctl.sv
// Scoreboard bench for game_state_ctl: driver queues expected screens, monitor checks on each state_chg.
module tb_game_state_ctl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_click = 1'b0;
    logic        shot_valid = 1'b0;
    logic        shot_goal = 1'b0;
    game_state_t game_state;
    logic [3:0]  score_player, score_cpu, round_idx;
    logic        state_chg;

    game_state_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start_click (start_click),
        .shot_valid  (shot_valid),
        .shot_goal   (shot_goal),
        .game_state  (game_state),
        .score_player(score_player),
        .score_cpu   (score_cpu),
        .round_idx   (round_idx),
        .state_chg   (state_chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int sp;
        int sc;
        int rd;
        int cy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   chg_cnt = 0;
    int   m_sp = 0, m_sc = 0, m_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && state_chg) begin
            chg_cnt++;
            chk("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("game_state", int'(game_state), mon_e.st);
                chk("score_player", int'(score_player), mon_e.sp);
                chk("score_cpu", int'(score_cpu), mon_e.sc);
                chk("round_idx", int'(round_idx), mon_e.rd);
                if (mon_e.cy >= 0) chk("chg_cycle", cyc, mon_e.cy);
            end
        end
    end

    task automatic exp_push(input game_state_t st, input int rd);
        exp_t e;
        e.st = int'(st);
        e.sp = m_sp;
        e.sc = m_sc;
        e.rd = rd;
        e.cy = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic step(input bit c, input bit s, input bit g, input bit t);
        start_click = c;
        shot_valid  = s;
        shot_goal   = g;
        frame_tick  = t;
        @(negedge clk);
        start_click = 1'b0;
        shot_valid  = 1'b0;
        shot_goal   = 1'b0;
        frame_tick  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic turn(input bit g, input game_state_t after, input bit coin);
        if (coin) begin
            exp_push(after, m_rd);
            step(1'b0, 1'b1, g, 1'b1);
        end else begin
            step(1'b0, 1'b1, g, 1'b0);
            idle(1);
            exp_push(after, m_rd);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        idle(1);
    endtask

    task automatic play_round(input bit pg, input bit cg, input game_state_t after, input bit coin);
        m_sp += int'(pg);
        turn(pg, KEEPER, coin);
        m_sc += int'(cg);
        if (after == SHOOTER) m_rd++;
        turn(cg, after, !coin);
    endtask

    task automatic start_game();
        m_sp = 0;
        m_sc = 0;
        m_rd = 1;
        exp_push(SHOOTER, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic end_by_click();
        m_rd = 0;
        exp_push(START, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and idle frames
        #1;
        chk("rst_state", int'(game_state), int'(START));
        chk("rst_round", int'(round_idx), 0);
        chk("rst_chg", int'(state_chg), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        chk("idle_state", int'(game_state), int'(START));
        chk("idle_score_p", int'(score_player), 0);
        chk("idle_score_c", int'(score_cpu), 0);
        chk("idle_round", int'(round_idx), 0);
        chk("idle_no_chg", chg_cnt, 0);

        // click at cycle 10, frame_tick at 50 -> SHOOTER at 51
        while (cyc < 10) @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        while (cyc < 50) @(negedge clk);
        chk("wait_for_tick", int'(game_state), int'(START));
        m_sp = 0; m_sc = 0; m_rd = 1;
        exp_push(SHOOTER, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("chg_one_cycle", int'(state_chg), 0);

        // game A: goal then miss before tick counts once; coincident shot; ends WINNER 5/3
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        m_sp = 1;
        exp_push(KEEPER, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        m_rd = 2;
        exp_push(SHOOTER, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("click_ignored_in_play", int'(game_state), int'(SHOOTER));
        play_round(1'b1, 1'b1, SHOOTER, 1'b0);
        play_round(1'b1, 1'b1, SHOOTER, 1'b1);
        play_round(1'b1, 1'b1, SHOOTER, 1'b0);
        play_round(1'b1, 1'b0, WINNER, 1'b1);
        repeat (300) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        chk("winner_held", int'(game_state), int'(WINNER));
        end_by_click();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("shot_ignored_start", int'(game_state), int'(START));
        chk("start_holds_sp", int'(score_player), 5);
        chk("start_holds_sc", int'(score_cpu), 3);

        // game B: miss then goal before tick counts as miss; ends LOOSER 2/3
        start_game();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        exp_push(KEEPER, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        m_sc = 1; m_rd = 2;
        exp_push(SHOOTER, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        play_round(1'b1, 1'b1, SHOOTER, 1'b0);
        play_round(1'b0, 1'b0, SHOOTER, 1'b1);
        play_round(1'b0, 1'b1, SHOOTER, 1'b0);
        play_round(1'b1, 1'b0, LOOSER, 1'b0);
        end_by_click();

        // game C: 5/5 after regulation, sudden-death round 6 -> WINNER, then 600-frame timeout
        start_game();
        for (int r = 0; r < 5; r++) play_round(1'b1, 1'b1, SHOOTER, r[0]);
        play_round(1'b1, 1'b0, WINNER, 1'b0);
        repeat (599) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        chk("timer_not_early", int'(game_state), int'(WINNER));
        m_rd = 0;
        exp_push(START, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // game D: ties through round 15 -> LOOSER 15/15
        start_game();
        for (int r = 0; r < 14; r++) play_round(1'b1, 1'b1, SHOOTER, r[0]);
        play_round(1'b1, 1'b1, LOOSER, 1'b0);
        end_by_click();

        // asynchronous reset in KEEPER with a shot pending
        start_game();
        m_sp = 1;
        turn(1'b1, KEEPER, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", int'(game_state), int'(START));
        chk("arst_score_p", int'(score_player), 0);
        chk("arst_score_c", int'(score_cpu), 0);
        chk("arst_round", int'(round_idx), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("post_rst_state", int'(game_state), int'(START));

        idle(4);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
